// File: rtl/spi_controller.sv
`timescale 1ns/1ps
// spi_controller: SPI Mode 0 (CPOL=0, CPHA=0) master issuing 16-bit frames
// {rw, addr[6:0], data[7:0]} MSB first to the spi_peripheral register block.
// One request at a time over req_valid/req_ready. ncs, sclk and copi are all
// registered, and the edge rate is slow enough for the peripheral's 2-flop
// input synchronisers.
//
// Optional feature macro: SPI_CTRL_CIPO_EN
//   When defined, adds the cipo input and the rsp_data output. cipo is
//   synchronised, sampled at the end of every sclk high phase, and the last
//   8 bits of each frame are presented on rsp_data when done pulses.
//
// Parameter limits: CLK_DIV >= 3, CS_SETUP >= 1, CS_HOLD >= 1, CS_GAP >= 4.
module spi_controller #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
`ifdef SPI_CTRL_CIPO_EN
  ,
  input  logic       cipo,
  output logic [7:0] rsp_data
`endif
);

  // The duration counter must hold the largest phase length without wrapping.
  localparam int DUR_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int DUR_MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int DUR_MAX   = (DUR_MAX_A > DUR_MAX_B) ? DUR_MAX_A : DUR_MAX_B;
  localparam int DUR_W     = $clog2(DUR_MAX + 1);

  // Each phase loads (length - 1) and leaves on the cycle the count hits zero.
  localparam logic [DUR_W-1:0] SETUP_LOAD = DUR_W'(CS_SETUP - 1);
  localparam logic [DUR_W-1:0] DIV_LOAD   = DUR_W'(CLK_DIV - 1);
  localparam logic [DUR_W-1:0] HOLD_LOAD  = DUR_W'(CS_HOLD - 1);
  // GAP is one cycle shorter than CS_GAP because the IDLE cycle in which the
  // next request is accepted also has ncs high. A request held valid therefore
  // sees exactly CS_GAP cycles of ncs high between frames.
  localparam logic [DUR_W-1:0] GAP_LOAD   = DUR_W'(CS_GAP - 2);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    GAP
  } state_t;

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] dur_reg,   dur_next;
  logic [3:0]       bit_reg,   bit_next;
  logic [15:0]      frame_reg, frame_next;
  logic             ncs_reg,   ncs_next;
  logic             sclk_reg,  sclk_next;
  logic             copi_reg,  copi_next;
  logic             done_reg,  done_next;
  logic             dur_zero;

  assign dur_zero = (dur_reg == '0);

  // State, counters, latched frame and the registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dur_reg   <= '0;
      bit_reg   <= 4'd0;
      frame_reg <= 16'h0000;
      ncs_reg   <= 1'b1;
      sclk_reg  <= 1'b0;
      copi_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dur_reg   <= dur_next;
      bit_reg   <= bit_next;
      frame_reg <= frame_next;
      ncs_reg   <= ncs_next;
      sclk_reg  <= sclk_next;
      copi_reg  <= copi_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: phase sequencing, bit shifting and pin updates.
  always_comb begin
    state_next = state_reg;
    dur_next   = dur_reg;
    bit_next   = bit_reg;
    frame_next = frame_reg;
    ncs_next   = ncs_reg;
    sclk_next  = sclk_reg;
    copi_next  = copi_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Request fields are captured here only, so later input changes
        // cannot disturb a frame in flight.
        if (req_valid) begin
          frame_next = {req_write, req_addr, req_data};
          ncs_next   = 1'b0;
          sclk_next  = 1'b0;
          copi_next  = req_write;
          bit_next   = 4'd15;
          dur_next   = SETUP_LOAD;
          state_next = SETUP;
        end
      end

      SETUP: begin
        if (dur_zero) begin
          sclk_next  = 1'b1;
          dur_next   = DIV_LOAD;
          state_next = SCK_HI;
        end else begin
          dur_next = dur_reg - 1'b1;
        end
      end

      SCK_HI: begin
        if (dur_zero) begin
          sclk_next = 1'b0;
          if (bit_reg == 4'd0) begin
            dur_next   = HOLD_LOAD;
            state_next = HOLD;
          end else begin
            // Mode 0: data changes on the falling edge, ahead of the next rise.
            bit_next   = bit_reg - 4'd1;
            copi_next  = frame_reg[bit_reg - 4'd1];
            dur_next   = DIV_LOAD;
            state_next = SCK_LO;
          end
        end else begin
          dur_next = dur_reg - 1'b1;
        end
      end

      SCK_LO: begin
        if (dur_zero) begin
          sclk_next  = 1'b1;
          dur_next   = DIV_LOAD;
          state_next = SCK_HI;
        end else begin
          dur_next = dur_reg - 1'b1;
        end
      end

      HOLD: begin
        if (dur_zero) begin
          ncs_next   = 1'b1;
          copi_next  = 1'b0;
          done_next  = 1'b1;
          dur_next   = GAP_LOAD;
          state_next = GAP;
        end else begin
          dur_next = dur_reg - 1'b1;
        end
      end

      GAP: begin
        if (dur_zero) begin
          state_next = IDLE;
        end else begin
          dur_next = dur_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign ncs       = ncs_reg;
  assign sclk      = sclk_reg;
  assign copi      = copi_reg;

`ifdef SPI_CTRL_CIPO_EN
  logic [1:0] cipo_sync;
  logic [7:0] shift_reg;
  logic [7:0] rsp_reg;

  // Two-flop synchroniser; cipo is launched by the peripheral's own clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_sync <= 2'b00;
    end else begin
      cipo_sync <= {cipo_sync[0], cipo};
    end
  end

  // Sample at the end of each high phase, when the peripheral's data has had
  // the whole low and high phase to settle through the synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
    end else if ((state_reg == SCK_HI) && dur_zero) begin
      shift_reg <= {shift_reg[6:0], cipo_sync[1]};
    end
  end

  // Publish the captured byte on the same edge that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_reg <= 8'h00;
    end else if ((state_reg == HOLD) && dur_zero) begin
      rsp_reg <= shift_reg;
    end
  end

  assign rsp_data = rsp_reg;
`endif

endmodule

// File: tb/tb_spi_controller.sv
`timescale 1ns/1ps
// tb_spi_controller: scoreboard bench for spi_controller. Two instances run
// side by side: g_dut[0] with default timing, g_dut[1] with the minimum
// divider (CLK_DIV=3, CS_GAP=4). The stimulus pushes hand-computed frames
// into a queue; a bus monitor rebuilds each frame from copi at the sclk rises
// and checks it against the queue whenever done pulses.
module tb_spi_controller;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [NI];
  logic       req_valid [NI];
  logic       req_ready [NI];
  logic       req_write [NI];
  logic [6:0] req_addr  [NI];
  logic [7:0] req_data  [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       ncs       [NI];
  logic       sclk      [NI];
  logic       copi      [NI];
`ifdef SPI_CTRL_CIPO_EN
  logic       cipo      [NI];
  logic [7:0] rsp_data  [NI];
`endif

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      spi_controller #(
        .CLK_DIV  ((gi == 0) ? 4 : 3),
        .CS_SETUP (4),
        .CS_HOLD  (4),
        .CS_GAP   ((gi == 0) ? 8 : 4)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n[gi]),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_write (req_write[gi]),
        .req_addr  (req_addr[gi]),
        .req_data  (req_data[gi]),
        .busy      (busy[gi]),
        .done      (done[gi]),
        .ncs       (ncs[gi]),
        .sclk      (sclk[gi]),
        .copi      (copi[gi])
`ifdef SPI_CTRL_CIPO_EN
        ,
        .cipo      (cipo[gi]),
        .rsp_data  (rsp_data[gi])
`endif
      );
    end
  endgenerate

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  // Pattern the cipo stub returns over frame bits 15:0; low bytes 0x3C / 0x5A.
  function automatic logic [15:0] pat_of(input int i);
    return (i == 0) ? 16'hA53C : 16'h965A;
  endfunction

  typedef struct {
    int          inst;
    logic [15:0] frame;
    int          gap;
    logic [7:0]  rsp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor state per instance.
  int          ncs_low_cnt [NI];
  int          high_cnt    [NI];
  int          last_gap    [NI];
  int          rises       [NI];
  int          run         [NI];
  int          done_seen   [NI];
  logic [15:0] shreg       [NI];
  logic        ncs_p       [NI];
  logic        sclk_p      [NI];
  logic        done_p      [NI];
  logic [7:0]  rsp_hold    [NI];

  // Bus monitor and scoreboard checker (plus cipo stub when enabled).
  initial begin : monitor
    for (int i = 0; i < NI; i++) begin
      ncs_low_cnt[i] = 0; high_cnt[i] = 0; last_gap[i] = -1; rises[i] = 0;
      run[i] = 0; done_seen[i] = 0; shreg[i] = 16'h0; ncs_p[i] = 1'b1;
      sclk_p[i] = 1'b0; done_p[i] = 1'b0; rsp_hold[i] = 8'h00;
`ifdef SPI_CTRL_CIPO_EN
      cipo[i] = 1'b0;
`endif
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n[i]) begin
          ncs_p[i] = 1'b1; sclk_p[i] = 1'b0; done_p[i] = 1'b0;
          rises[i] = 0; run[i] = 0; ncs_low_cnt[i] = 0; rsp_hold[i] = 8'h00;
        end else begin
          // Chip-select low length and the high gap that preceded it.
          if (!ncs[i]) begin
            if (ncs_p[i]) begin
              last_gap[i] = high_cnt[i];
              ncs_low_cnt[i] = 0; rises[i] = 0; shreg[i] = 16'h0; run[i] = 0;
`ifdef SPI_CTRL_CIPO_EN
              cipo[i] = pat_of(i)[15];
`endif
            end
            ncs_low_cnt[i]++;
          end else begin
            if (!ncs_p[i]) high_cnt[i] = 0;
            high_cnt[i]++;
          end
          // sclk phase lengths and copi sampled at each rise.
          if (sclk[i] != sclk_p[i]) begin
            if (sclk_p[i]) begin
              check("sclk_high_len", 32'(run[i]), 32'(div_of(i)));
            end else if (rises[i] > 0) begin
              check("sclk_low_len", 32'(run[i]), 32'(div_of(i)));
            end
            run[i] = 0;
            if (sclk[i]) begin
              rises[i]++;
              shreg[i] = {shreg[i][14:0], copi[i]};
            end
`ifdef SPI_CTRL_CIPO_EN
            else begin
              cipo[i] = (rises[i] < 16) ? pat_of(i)[15 - rises[i]] : 1'b0;
            end
`endif
          end
          run[i]++;
          // Completed frame: compare against the scoreboard.
          if (done[i]) begin
            check("done_width", 32'(done_p[i]), 32'd0);
            done_seen[i]++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_done: inst %0d frame 0x%04h, no frame expected", i, shreg[i]);
            end else begin
              mon_e = exp_q.pop_front();
              check("frame_inst", 32'(i), 32'(mon_e.inst));
              check("frame_bits", 32'(shreg[i]), 32'(mon_e.frame));
              check("sclk_rises", 32'(rises[i]), 32'd16);
              check("ncs_low_len", 32'(ncs_low_cnt[i]), 32'(8 + 31 * div_of(i)));
              if (mon_e.gap >= 0) check("ncs_gap", 32'(last_gap[i]), 32'(mon_e.gap));
`ifdef SPI_CTRL_CIPO_EN
              check("rsp_data", 32'(rsp_data[i]), 32'(mon_e.rsp));
              rsp_hold[i] = rsp_data[i];
`endif
              $display("inst %0d frame 0x%04h (expected 0x%04h) ncs_low %0d gap %0d",
                       i, shreg[i], mon_e.frame, ncs_low_cnt[i], last_gap[i]);
            end
          end
`ifdef SPI_CTRL_CIPO_EN
          else begin
            check("rsp_hold", 32'(rsp_data[i]), 32'(rsp_hold[i]));
          end
`endif
          ncs_p[i] = ncs[i]; sclk_p[i] = sclk[i]; done_p[i] = done[i];
        end
      end
    end
  end

  // Present a request and return on the falling edge after it is accepted.
  task automatic issue(input int i, input logic w, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] exp_frame, input int gap, input bit push);
    int t;
    exp_t e;
    logic [15:0] p;
    req_write[i] = w; req_addr[i] = a; req_data[i] = d; req_valid[i] = 1'b1;
    if (push) begin
      p = pat_of(i);
      e.inst = i; e.frame = exp_frame; e.gap = gap; e.rsp = p[7:0];
      exp_q.push_back(e);
    end
    t = 0;
    while (!req_ready[i] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: inst %0d req_ready 0, required 1", i);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int i, input int n);
    int t;
    t = 0;
    while (done_seen[i] < n && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_count", 32'(done_seen[i]), 32'(n));
  endtask

  int t_wait;
  int ds_snap;

  initial begin : stimulus
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = 7'h00; req_data[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_ncs", 32'(ncs[i]), 32'd1);
      check("rst_sclk", 32'(sclk[i]), 32'd0);
      check("rst_copi", 32'(copi[i]), 32'd0);
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_done", 32'(done[i]), 32'd0);
`ifdef SPI_CTRL_CIPO_EN
      check("rst_rsp", 32'(rsp_data[i]), 32'd0);
`endif
      rst_n[i] = 1'b1;
    end
    @(negedge clk);
    for (int i = 0; i < NI; i++) check("ready_after_rst", 32'(req_ready[i]), 32'd1);

    // Single write, defaults: 0x8480.
    issue(0, 1'b1, 7'h04, 8'h80, 16'h8480, -1, 1'b1);
    req_valid[0] = 1'b0;
    wait_done(0, 1);

    // Back-to-back with req_valid held: 0x80FF then 0x8155, gap 8.
    issue(0, 1'b1, 7'h00, 8'hFF, 16'h80FF, -1, 1'b1);
    issue(0, 1'b1, 7'h01, 8'h55, 16'h8155, 8, 1'b1);
    req_valid[0] = 1'b0;
    wait_done(0, 3);

    // Busy stability: read frame 0x2A3C, inputs scrambled while busy.
    issue(0, 1'b0, 7'h2A, 8'h3C, 16'h2A3C, -1, 1'b1);
    t_wait = 0;
    while (busy[0] && t_wait < 1000) begin
      check("ready_while_busy", 32'(req_ready[0]), 32'd0);
      req_addr[0] = 7'($urandom);
      req_data[0] = 8'($urandom);
      @(negedge clk);
      t_wait++;
    end
    req_valid[0] = 1'b0;
    wait_done(0, 4);

    // Minimum divider instance: 0x82A5 then 0x825A back-to-back, gap 4.
    issue(1, 1'b1, 7'h02, 8'hA5, 16'h82A5, -1, 1'b1);
    issue(1, 1'b1, 7'h02, 8'h5A, 16'h825A, 4, 1'b1);
    req_valid[1] = 1'b0;
    wait_done(1, 2);

    // Reset after the 7th sclk rise: pins return at once, no done.
    issue(0, 1'b1, 7'h03, 8'h99, 16'h8399, -1, 1'b0);
    req_valid[0] = 1'b0;
    t_wait = 0;
    while (rises[0] < 7 && t_wait < 500) begin
      @(negedge clk);
      #1;
      t_wait++;
    end
    check("rises_before_rst", 32'(rises[0]), 32'd7);
    ds_snap = done_seen[0];
    #1 rst_n[0] = 1'b0;
    #1;
    check("async_rst_ncs", 32'(ncs[0]), 32'd1);
    check("async_rst_sclk", 32'(sclk[0]), 32'd0);
    check("async_rst_copi", 32'(copi[0]), 32'd0);
    check("async_rst_busy", 32'(busy[0]), 32'd0);
    check("async_rst_done", 32'(done[0]), 32'd0);
    repeat (4) @(negedge clk);
    #1 rst_n[0] = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_rst", 32'(done_seen[0]), 32'(ds_snap));
`ifdef SPI_CTRL_CIPO_EN
    check("rsp_after_rst", 32'(rsp_data[0]), 32'd0);
`endif
    issue(0, 1'b1, 7'h03, 8'hC3, 16'h83C3, -1, 1'b1);
    req_valid[0] = 1'b0;
    wait_done(0, ds_snap + 1);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
